// File: rtl/decode_queue_mw.sv
// Multi-lane circular instruction queue between fetch and decode.
// Optional statistics ports are enabled by defining DECODE_QUEUE_STATS_EN.
module decode_queue_mw #(
    parameter int DEPTH   = 8,
    parameter int ENQ_W   = 2,
    parameter int DEQ_W   = 2,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         flush,
    input  logic                         stall,
    input  logic [ENQ_W-1:0]             enq_valid,
    input  logic [ENQ_W*INSTR_W-1:0]     enq_instr,
    input  logic [ENQ_W*PC_W-1:0]        enq_pc,
    input  logic [ENQ_W*PC_W-1:0]        enq_pc_plus4,
    output logic                         enq_ready,
    output logic [DEQ_W-1:0]             deq_valid,
    output logic [DEQ_W*INSTR_W-1:0]     deq_instr,
    output logic [DEQ_W*PC_W-1:0]        deq_pc,
    output logic [DEQ_W*PC_W-1:0]        deq_pc_plus4,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
    output logic [CNT_W-1:0]             count,
    output logic                         full,
    output logic                         empty
`ifdef DECODE_QUEUE_STATS_EN
    ,
    output logic [CNT_W-1:0]             stat_peak,
    output logic [31:0]                  stat_stall_cyc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: enqueue lanes are accepted on an edge where enq_ready && !stall && !flush;
    // deq_valid[k] marks lane k readable and deq_take lanes retire on an edge where !stall && !flush.

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [INSTR_W-1:0] instr_d [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [PC_W-1:0]    pc_d    [DEPTH];
    logic [PC_W-1:0]    pc4_q   [DEPTH];
    logic [PC_W-1:0]    pc4_d   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] take_ext;
    logic [CNT_W-1:0] eff_take;
    logic [PTR_W-1:0] slot;
    logic [PTR_W-1:0] rd_idx;
    logic             enq_fire;

    // Ready looks only at the registered count, so a same-cycle dequeue never frees space early.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        enq_ready  = free_slots >= CNT_W'(ENQ_W);
        enq_fire   = enq_ready && !stall && !flush;
        take_ext   = CNT_W'(deq_take);
        eff_take   = (take_ext > count_q) ? count_q : take_ext;
    end

    // Valid lanes are packed into consecutive slots starting at wr_ptr.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        n_enq   = '0;
        slot    = '0;
        for (int k = 0; k < ENQ_W; k++) begin
            if (enq_valid[k]) begin
                slot = wr_ptr_q + PTR_W'(n_enq);
                if (enq_fire) begin
                    instr_d[slot] = enq_instr[k*INSTR_W +: INSTR_W];
                    pc_d[slot]    = enq_pc[k*PC_W +: PC_W];
                    pc4_d[slot]   = enq_pc_plus4[k*PC_W +: PC_W];
                end
                n_enq = n_enq + 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (!stall) begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(eff_take);
            count_d  = count_q + (enq_fire ? n_enq : '0) - eff_take;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
        end
    end

    // Stale storage beyond count is masked to zero on the read lanes.
    always_comb begin
        deq_valid    = '0;
        deq_instr    = '0;
        deq_pc       = '0;
        deq_pc_plus4 = '0;
        rd_idx       = '0;
        for (int k = 0; k < DEQ_W; k++) begin
            rd_idx       = rd_ptr_q + PTR_W'(k);
            deq_valid[k] = count_q > CNT_W'(k);
            if (deq_valid[k]) begin
                deq_instr[k*INSTR_W +: INSTR_W] = instr_q[rd_idx];
                deq_pc[k*PC_W +: PC_W]          = pc_q[rd_idx];
                deq_pc_plus4[k*PC_W +: PC_W]    = pc4_q[rd_idx];
            end
        end
    end

    assign count = count_q;
    assign full  = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;

`ifdef DECODE_QUEUE_STATS_EN
    logic [CNT_W-1:0] peak_q, peak_d;
    logic [31:0]      stall_cyc_q, stall_cyc_d;

    // Peak survives flush; back-pressure counter saturates instead of wrapping.
    always_comb begin
        peak_d      = (count_q > peak_q) ? count_q : peak_q;
        stall_cyc_d = stall_cyc_q;
        if ((|enq_valid) && !enq_ready && (stall_cyc_q != 32'hFFFF_FFFF)) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            peak_q      <= '0;
            stall_cyc_q <= '0;
        end else begin
            peak_q      <= peak_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign stat_peak      = peak_q;
    assign stat_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_decode_queue_mw.sv
// Bench for decode_queue_mw: directed stimulus with an expected-entry queue
// checked against every visible dequeue lane on each falling edge.
module tb_decode_queue_mw;

    localparam int DEPTH   = 8;
    localparam int ENQ_W   = 2;
    localparam int DEQ_W   = 2;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int EW      = INSTR_W + 2 * PC_W;

    logic                       CLK;
    logic                       RESET;
    logic                       flush;
    logic                       stall;
    logic [ENQ_W-1:0]           enq_valid;
    logic [ENQ_W*INSTR_W-1:0]   enq_instr;
    logic [ENQ_W*PC_W-1:0]      enq_pc;
    logic [ENQ_W*PC_W-1:0]      enq_pc_plus4;
    logic                       enq_ready;
    logic [DEQ_W-1:0]           deq_valid;
    logic [DEQ_W*INSTR_W-1:0]   deq_instr;
    logic [DEQ_W*PC_W-1:0]      deq_pc;
    logic [DEQ_W*PC_W-1:0]      deq_pc_plus4;
    logic [$clog2(DEQ_W+1)-1:0] deq_take;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;

    logic [EW-1:0] exp_q[$];
    int checks;
    int fails;
    bit check_en;

    decode_queue_mw #(
        .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W),
        .INSTR_W(INSTR_W), .PC_W(PC_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .flush(flush), .stall(stall),
        .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_pc(enq_pc),
        .enq_pc_plus4(enq_pc_plus4), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
        .deq_pc_plus4(deq_pc_plus4), .deq_take(deq_take),
        .count(count), .full(full), .empty(empty)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        enq_valid    = '0;
        enq_instr    = '0;
        enq_pc       = '0;
        enq_pc_plus4 = '0;
        deq_take     = '0;
        stall        = 1'b0;
        flush        = 1'b0;
    endtask

    // Drive one cycle of stimulus, return 1ns after the edge with inputs idle.
    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] take, input logic st, input logic fl);
        enq_valid    = v;
        enq_instr    = {i1, i0};
        enq_pc       = {p1, p0};
        enq_pc_plus4 = {p1 + 32'd4, p0 + 32'd4};
        deq_take     = take;
        stall        = st;
        flush        = fl;
        @(posedge CLK);
        #1;
        set_idle();
    endtask

    // Scoreboard: compare visible lanes with the expected queue, then apply the coming edge.
    always @(negedge CLK) begin
        if (check_en) begin
            int sz;
            int tk;
            logic [EW-1:0] e;
            sz = exp_q.size();
            check("sb_count", 64'(count), 64'(sz));
            check("sb_empty", 64'(empty), 64'(sz == 0));
            check("sb_full", 64'(full), 64'(sz == DEPTH));
            check("sb_enq_ready", 64'(enq_ready), 64'((DEPTH - sz) >= ENQ_W));
            for (int k = 0; k < DEQ_W; k++) begin
                e = (k < sz) ? exp_q[k] : '0;
                check("sb_deq_valid", 64'(deq_valid[k]), 64'(k < sz));
                check("sb_deq_instr", 64'(deq_instr[k*INSTR_W +: INSTR_W]), 64'(e[EW-1 -: INSTR_W]));
                check("sb_deq_pc", 64'(deq_pc[k*PC_W +: PC_W]), 64'(e[2*PC_W-1 -: PC_W]));
                check("sb_deq_pc4", 64'(deq_pc_plus4[k*PC_W +: PC_W]), 64'(e[PC_W-1:0]));
            end
            if (!RESET || flush) begin
                exp_q.delete();
            end else if (!stall) begin
                tk = (int'(deq_take) > sz) ? sz : int'(deq_take);
                for (int j = 0; j < tk; j++) void'(exp_q.pop_front());
                if ((DEPTH - sz) >= ENQ_W) begin
                    for (int k = 0; k < ENQ_W; k++) begin
                        if (enq_valid[k]) begin
                            exp_q.push_back({enq_instr[k*INSTR_W +: INSTR_W],
                                             enq_pc[k*PC_W +: PC_W],
                                             enq_pc_plus4[k*PC_W +: PC_W]});
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        fails    = 0;
        check_en = 1'b0;
        set_idle();
        RESET = 1'b1;
        #1 RESET = 1'b0;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_deq_instr", 64'(deq_instr), 64'd0);
        #19 RESET = 1'b1;
        @(posedge CLK);
        #1;
        check_en = 1'b1;

        // Two entries, then an idle cycle
        drive(2'b11, 32'h11, 32'h22, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        check("two_count", 64'(count), 64'd2);
        check("two_valid", 64'(deq_valid), 64'b11);
        check("two_lane0", 64'(deq_instr[31:0]), 64'h11);
        check("two_lane1", 64'(deq_instr[63:32]), 64'h22);
        check("two_pc1", 64'(deq_pc[63:32]), 64'h104);

        // Fill to 8, then an ignored enqueue
        drive(2'b11, 32'h33, 32'h44, 32'h108, 32'h10c, 2'd0, 1'b0, 1'b0);
        drive(2'b11, 32'h55, 32'h66, 32'h110, 32'h114, 2'd0, 1'b0, 1'b0);
        check("fill6_ready", 64'(enq_ready), 64'd1);
        drive(2'b11, 32'h77, 32'h88, 32'h118, 32'h11c, 2'd0, 1'b0, 1'b0);
        check("fill_full", 64'(full), 64'd1);
        check("fill_ready", 64'(enq_ready), 64'd0);
        drive(2'b01, 32'h99, 32'h0, 32'h120, 32'h0, 2'd0, 1'b0, 1'b0);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_lane0", 64'(deq_instr[31:0]), 64'h11);

        // Drain: count 7 still not ready, then clamp with one left
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        check("c7_count", 64'(count), 64'd7);
        check("c7_ready", 64'(enq_ready), 64'd0);
        for (int i = 0; i < 3; i++) drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check("c1_count", 64'(count), 64'd1);
        check("c1_lane0", 64'(deq_instr[31:0]), 64'h88);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check("clamp_count", 64'(count), 64'd0);
        check("clamp_empty", 64'(empty), 64'd1);

        // Lane-1-only enqueue compacts into the head slot
        drive(2'b10, 32'hdead, 32'h55, 32'h300, 32'h200, 2'd0, 1'b0, 1'b0);
        check("cmp_count", 64'(count), 64'd1);
        check("cmp_lane0", 64'(deq_instr[31:0]), 64'h55);
        check("cmp_pc0", 64'(deq_pc[31:0]), 64'h200);
        check("cmp_lane1_valid", 64'(deq_valid[1]), 64'd0);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);

        // Steady state: two in, two out, pointers wrap repeatedly
        drive(2'b11, 32'h1000, 32'h1001, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive(2'b11, 32'h1000 + 32'(2*i), 32'h1001 + 32'(2*i),
                  32'h100 + 32'(8*i), 32'h104 + 32'(8*i), 2'd2, 1'b0, 1'b0);
            check("steady_count", 64'(count), 64'd2);
        end
        check("steady_pc0", 64'(deq_pc[31:0]), 64'h1a0);

        // Stall holds everything; flush under stall clears
        drive(2'b11, 32'haa, 32'hbb, 32'h400, 32'h404, 2'd2, 1'b1, 1'b0);
        check("stall_count", 64'(count), 64'd2);
        check("stall_lane0", 64'(deq_instr[31:0]), 64'h1028);
        drive(2'b11, 32'hcc, 32'hdd, 32'h408, 32'h40c, 2'd2, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(deq_valid), 64'd0);
        check("flush_instr", 64'(deq_instr), 64'd0);

        // Asynchronous reset between edges
        drive(2'b11, 32'hee, 32'hff, 32'h500, 32'h504, 2'd0, 1'b0, 1'b0);
        check("pre_arst_count", 64'(count), 64'd2);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(deq_valid), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1;
        drive(2'b11, 32'h123, 32'h456, 32'h600, 32'h604, 2'd0, 1'b0, 1'b0);
        check("post_arst_lane1", 64'(deq_instr[63:32]), 64'h456);
        check("post_arst_pc4", 64'(deq_pc_plus4[31:0]), 64'h604);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check("end_empty", 64'(empty), 64'd1);
        repeat (2) @(posedge CLK);
        #1;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/decode_queue_mw.md
Name: decode_queue_mw

Overview:
- Parametrised circular-buffer instruction queue between fetch (IF) and decode (ID).
- Accepts up to ENQ_W fetched instructions per cycle and presents the oldest DEQ_W entries to ID in program order.
- Supports partial dequeue, a global stall, and a flush for branch mispredict recovery.
- Successor to the fixed 8-entry, single-lane shift queue; read/write pointers replace the shift register.

Parameters:
- DEPTH, 8, entry count; power of 2, at least 4, at least ENQ_W and DEQ_W.
- ENQ_W, 2, enqueue lanes per cycle (1..4).
- DEQ_W, 2, dequeue lanes per cycle (1..4).
- INSTR_W, 32, instruction width.
- PC_W, 32, width of PC and PC+4.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries.
- stall  in  1  freeze enqueue and dequeue.
- enq_valid  in  ENQ_W  per-lane valid; lane 0 is oldest.
- enq_instr  in  ENQ_W*INSTR_W  lane k at bits [k*INSTR_W +: INSTR_W].
- enq_pc  in  ENQ_W*PC_W  instruction PC per lane.
- enq_pc_plus4  in  ENQ_W*PC_W  PC+4 per lane.
- enq_ready  out  1  free slots >= ENQ_W.
- deq_valid  out  DEQ_W  deq_valid[k] = (count > k).
- deq_instr  out  DEQ_W*INSTR_W  k-th oldest entry; 0 when lane invalid.
- deq_pc  out  DEQ_W*PC_W  PC of k-th oldest entry; 0 when lane invalid.
- deq_pc_plus4  out  DEQ_W*PC_W  PC+4 of k-th oldest entry; 0 when lane invalid.
- deq_take  in  $clog2(DEQ_W+1)  number of entries ID consumes this cycle.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, RESET=0):
  - rd_ptr = wr_ptr = count = 0; all storage cleared to 0.
  - Outputs: deq_valid=0, deq_* data=0, empty=1, full=0, enq_ready=1.
- All state updates on the rising CLK edge. Outputs are combinational from registered state only; no same-cycle bypass.
- Enqueue:
  - Active when enq_ready && !stall && !flush.
  - Valid lanes are compacted in lane order: valid lanes are written to wr_ptr, wr_ptr+1, … with no holes.
  - n_enq = popcount(enq_valid).
  - When enq_ready=0, inputs are ignored; upstream must hold them.
- Dequeue:
  - eff_take = min(deq_take, count).
  - When !stall && !flush: rd_ptr += eff_take.
  - Dequeued slots are not cleared.
- Same-cycle enqueue and dequeue:
  - count_next = count + n_enq - eff_take.
  - enq_ready is computed from the pre-dequeue count (no ready-through).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Lane reads use (rd_ptr+k) mod DEPTH.
- Stall: holds all state; outputs stay stable.
- Flush:
  - Has priority over stall, enqueue and dequeue.
  - Next edge: rd_ptr = wr_ptr = count = 0; same-cycle enqueue is discarded.
  - Storage is not cleared; outputs read 0 through the validity mask.
- RESET asserted mid-operation: immediate async clear, regardless of CLK, stall or flush.
- enq_valid and deq_take have no X-propagation guard; the bench must drive them known out of reset.

Optional Feature:
- Macro: DECODE_QUEUE_STATS_EN.
- When defined, add output stat_peak (CNT_W bits): highest count since reset. Not cleared by flush.
- When defined, add output stat_stall_cyc (32 bits): cycles with enq_valid != 0 && !enq_ready; saturates at 0xFFFFFFFF.
- Both statistics reset to 0 on RESET.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle → count=0, empty=1, enq_ready=1, deq_valid=2'b00, deq_instr=0.
- Enqueue 0x11/0x22 (PCs 0x100, 0x104), deq_take=0, then one cycle with enq_valid=0 → deq_valid=2'b11, deq_instr lane0=0x11, lane1=0x22, count=2.
- Fill 8 entries with enq_valid=2'b11 over 4 cycles → full=1, enq_ready=0 from count 7. Further enqueue of 0x99 is ignored; count stays 8.
- enq_valid=2'b10 carrying 0x55 in lane 1 → compacted into slot wr_ptr; count +1; 0x55 appears in deq lane0 when the queue was empty.
- Steady state: enqueue 2, deq_take=2 for 20 cycles → pointers wrap; in-order PCs 0x100, 0x104, … continuous; count constant at 2.
- deq_take=2 with count=1 → eff_take=1 (clamped); count=0 (plus any same-cycle enqueue).
- stall=1 with deq_take=2 and enqueue 2 → count unchanged. Add flush=1 while stall=1 → count=0, deq_valid=0 next edge.
